// File: rtl/clk_enable_gen.sv
// clk_enable_gen: multi-channel clock-enable generator.
//
// Each of N_CH channels divides the master clock by its own programmable divisor.
// For every channel it produces a one-cycle tick (clock enable) and a 50%-duty
// square wave. All downstream logic stays on clk and is qualified with the ticks.
//
// Ports:
//   clk     in   1            master clock, rising edge
//   rst     in   1            synchronous active-high reset
//   en      in   N_CH         per-channel run enable (low pauses the channel)
//   sync    in   1            restart all channels in phase
//   wr_en   in   1            divisor write strobe
//   wr_ch   in   3            write target channel (>= N_CH is ignored)
//   wr_div  in   CNT_W        new divisor value
//   tick    out  N_CH         one-cycle pulse per channel period (registered)
//   sq      out  N_CH         square wave, toggles on every tick (registered)
//   div_q   out  N_CH*CNT_W   current divisor of every channel
module clk_enable_gen #(
  parameter int unsigned              N_CH     = 3,
  parameter int unsigned              CNT_W    = 32,
  parameter logic [N_CH*CNT_W-1:0]    DIV_INIT = {32'd2, 32'd65536, 32'd50000000}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          en,
  input  logic                     sync,
  input  logic                     wr_en,
  input  logic [2:0]               wr_ch,
  input  logic [CNT_W-1:0]         wr_div,
  output logic [N_CH-1:0]          tick,
  output logic [N_CH-1:0]          sq,
  output logic [N_CH*CNT_W-1:0]    div_q
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam logic [2:0] ChIdx = 3'(i);

    logic [CNT_W-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             sq_q, sq_d;
    logic             wr_hit;

    // Channels >= N_CH have no ChIdx, so out-of-range writes never match.
    assign wr_hit = wr_en && (wr_ch == ChIdx);

    always_comb begin
      divisor_d = divisor_q;
      count_d   = count_q;
      tick_d    = 1'b0;
      sq_d      = sq_q;
      if (sync) begin
        count_d = '0;
        sq_d    = 1'b0;
      end else if (wr_hit) begin
        // Restart the period under the new divisor; sq keeps its level.
        divisor_d = wr_div;
        count_d   = '0;
      end else if (divisor_q == '0) begin
        count_d = '0;
      end else if (en[i]) begin
        // divisor_q >= 1 here, so divisor_q - 1 cannot underflow.
        if (count_q == divisor_q - CNT_W'(1)) begin
          count_d = '0;
          tick_d  = 1'b1;
          sq_d    = ~sq_q;
        end else begin
          count_d = count_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        divisor_q <= DIV_INIT[i*CNT_W +: CNT_W];
        count_q   <= '0;
        tick_q    <= 1'b0;
        sq_q      <= 1'b0;
      end else begin
        divisor_q <= divisor_d;
        count_q   <= count_d;
        tick_q    <= tick_d;
        sq_q      <= sq_d;
      end
    end

    assign tick[i]                   = tick_q;
    assign sq[i]                     = sq_q;
    assign div_q[i*CNT_W +: CNT_W]   = divisor_q;
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed scenarios plus randomized traffic,
// all compared against an elapsed-cycle reference model.
module tb_clk_enable_gen;

  localparam int N = 3;
  localparam int W = 8;
  localparam logic [N*W-1:0] INIT = {8'd2, 8'd4, 8'd5};

  logic           clk = 1'b0;
  logic           rst, sync, wr_en;
  logic [N-1:0]   en;
  logic [2:0]     wr_ch;
  logic [W-1:0]   wr_div;
  logic [N-1:0]   tick, sq;
  logic [N*W-1:0] div_q;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: divisor, counting edges since the last restart, outputs.
  logic [W-1:0]   m_div [N];
  longint         m_el  [N];
  logic [N-1:0]   m_tick, m_sq;
  logic [N*W-1:0] m_divq;

  always #5 clk = ~clk;

  clk_enable_gen #(
    .N_CH     (N),
    .CNT_W    (W),
    .DIV_INIT (INIT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .sync   (sync),
    .wr_en  (wr_en),
    .wr_ch  (wr_ch),
    .wr_div (wr_div),
    .tick   (tick),
    .sq     (sq),
    .div_q  (div_q)
  );

  // One rising edge: advance the model from the inputs seen at the edge, then settle.
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        m_div[i] = INIT[i*W +: W]; m_el[i] = 0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
      end else if (sync) begin
        m_el[i] = 0; m_tick[i] = 1'b0; m_sq[i] = 1'b0;
      end else if (wr_en && int'(wr_ch) == i) begin
        m_div[i] = wr_div; m_el[i] = 0; m_tick[i] = 1'b0;
      end else if (m_div[i] == '0) begin
        m_el[i] = 0; m_tick[i] = 1'b0;
      end else if (!en[i]) begin
        m_tick[i] = 1'b0;
      end else begin
        m_el[i]++;
        // A tick lands on every multiple of the divisor since the restart.
        m_tick[i] = (m_el[i] % longint'(m_div[i])) == 0;
        if (m_tick[i]) m_sq[i] = ~m_sq[i];
      end
    end
    for (int i = 0; i < N; i++) m_divq[i*W +: W] = m_div[i];
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0; en = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (tick !== 3'b000) $display("FAIL reset tick: got %b exp 000", tick); else n_pass++;
    n_total++;
    if (sq !== 3'b000) $display("FAIL reset sq: got %b exp 000", sq); else n_pass++;
    n_total++;
    if (div_q !== INIT) $display("FAIL reset div_q: got %h exp %h", div_q, INIT);
    else n_pass++;
  endtask

  task automatic test_run();
    logic [N-1:0] exp_t;
    do_reset();
    en = 3'b111;
    for (int e = 1; e <= 20; e++) begin
      step();
      exp_t = {(e % 2) == 0, (e % 4) == 0, (e % 5) == 0};
      n_total++;
      if (tick !== exp_t) $display("FAIL run tick e=%0d: got %b exp %b", e, tick, exp_t);
      else n_pass++;
      n_total++;
      if (sq[1] !== 1'(((e / 4) % 2) == 1))
        $display("FAIL run sq1 e=%0d: got %b exp %b", e, sq[1], ((e / 4) % 2) == 1);
      else n_pass++;
      n_total++;
      if ({tick, sq, div_q} !== {m_tick, m_sq, m_divq})
        $display("FAIL run model e=%0d: got %b %b %h exp %b %b %h",
                 e, tick, sq, div_q, m_tick, m_sq, m_divq);
      else n_pass++;
    end
  endtask

  task automatic test_write();
    do_reset();
    en = 3'b111;
    for (int e = 1; e <= 12; e++) begin
      if (e == 6) begin wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd3; end
      step();
      wr_en = 1'b0;
      if (e == 6) begin
        n_total++;
        if (div_q[15:8] !== 8'd3) $display("FAIL write div_q: got %0d exp 3", div_q[15:8]);
        else n_pass++;
      end
      if (e >= 6) begin
        n_total++;
        if (tick[1] !== 1'(e == 9 || e == 12))
          $display("FAIL write tick1 e=%0d: got %b exp %b", e, tick[1], e == 9 || e == 12);
        else n_pass++;
      end
      n_total++;
      if ({tick, sq, div_q} !== {m_tick, m_sq, m_divq})
        $display("FAIL write model e=%0d: got %b %b %h exp %b %b %h",
                 e, tick, sq, div_q, m_tick, m_sq, m_divq);
      else n_pass++;
    end
  endtask

  task automatic test_disable();
    logic held, prev;
    do_reset();
    en = 3'b111;
    repeat (7) step();  // ch0 (div 5) ticked at edge 5, so sq[0] is high
    held = m_sq[0];
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd0;
    step();
    wr_en = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      n_total++;
      if (tick[0] !== 1'b0 || sq[0] !== held)
        $display("FAIL disable c=%0d: got tick %b sq %b exp tick 0 sq %b",
                 c, tick[0], sq[0], held);
      else n_pass++;
    end
    wr_en = 1'b1; wr_div = 8'd1;
    step();
    wr_en = 1'b0;
    prev = sq[0];
    for (int c = 0; c < 10; c++) begin
      step();
      n_total++;
      if (tick[0] !== 1'b1 || sq[0] !== ~prev)
        $display("FAIL div1 c=%0d: got tick %b sq %b exp tick 1 sq %b",
                 c, tick[0], sq[0], ~prev);
      else n_pass++;
      prev = ~prev;
    end
  endtask

  task automatic test_pause();
    do_reset();
    en = 3'b111;
    wr_en = 1'b1; wr_ch = 3'd2; wr_div = 8'd5;
    step();
    wr_en = 1'b0;
    repeat (3) step();  // ch2 count now 3 of 5
    en[2] = 1'b0;
    for (int c = 0; c < 7; c++) begin
      step();
      n_total++;
      if (tick[2] !== 1'b0) $display("FAIL pause tick2 c=%0d: got %b exp 0", c, tick[2]);
      else n_pass++;
    end
    en[2] = 1'b1;
    // Counting resumes from 3: one edge to reach 4, the next edge is terminal.
    for (int c = 1; c <= 12; c++) begin
      step();
      n_total++;
      if (tick[2] !== 1'(c == 2 || c == 7 || c == 12))
        $display("FAIL resume tick2 c=%0d: got %b exp %b", c, tick[2],
                 c == 2 || c == 7 || c == 12);
      else n_pass++;
      n_total++;
      if ({tick, sq, div_q} !== {m_tick, m_sq, m_divq})
        $display("FAIL pause model c=%0d: got %b %b %h exp %b %b %h",
                 c, tick, sq, div_q, m_tick, m_sq, m_divq);
      else n_pass++;
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    en = 3'b111;
    repeat (3) step();
    sync = 1'b1; wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd9;
    step();
    sync = 1'b0; wr_en = 1'b0;
    n_total++;
    if ({tick, sq, div_q} !== {3'b000, 3'b000, INIT})
      $display("FAIL sync+write: got %b %b %h exp 000 000 %h", tick, sq, div_q, INIT);
    else n_pass++;
    repeat (4) step();
    n_total++;
    if (tick[2:1] !== 2'b11) $display("FAIL sync coincident: got %b exp 11", tick[2:1]);
    else n_pass++;
    // ch1 count is 0; three edges bring it to 3, the fourth edge is terminal.
    repeat (3) step();
    wr_en = 1'b1; wr_ch = 3'd1; wr_div = 8'd4;
    step();
    wr_en = 1'b0;
    n_total++;
    if (tick[1] !== 1'b0) $display("FAIL write at terminal: got %b exp 0", tick[1]);
    else n_pass++;
    repeat (4) step();
    n_total++;
    if (tick[1] !== 1'b1) $display("FAIL post-write tick1: got %b exp 1", tick[1]);
    else n_pass++;
    wr_en = 1'b1; wr_ch = 3'd5; wr_div = 8'd1;
    step();
    wr_en = 1'b0;
    n_total++;
    if (div_q !== INIT || {tick, sq} !== {m_tick, m_sq})
      $display("FAIL wr_ch=5: got %h %b %b exp %h %b %b", div_q, tick, sq, INIT, m_tick, m_sq);
    else n_pass++;
    wr_en = 1'b1; wr_ch = 3'd0; wr_div = 8'd7;
    step();
    wr_en = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++;
    if ({tick, sq, div_q} !== {3'b000, 3'b000, INIT})
      $display("FAIL rst mid-count: got %b %b %h exp 000 000 %h", tick, sq, div_q, INIT);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst    = ($urandom_range(0, 299) == 0);
      sync   = ($urandom_range(0, 59) == 0);
      wr_en  = ($urandom_range(0, 7) == 0);
      wr_ch  = 3'($urandom_range(0, 7));
      wr_div = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255))
                                            : 8'($urandom_range(0, 7));
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
      step();
      n_total++;
      if ({tick, sq, div_q} !== {m_tick, m_sq, m_divq})
        $display("FAIL random c=%0d: got %b %b %h exp %b %b %h",
                 c, tick, sq, div_q, m_tick, m_sq, m_divq);
      else n_pass++;
    end
    rst = 1'b0; sync = 1'b0; wr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_write();
    test_disable();
    test_pause();
    test_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
